// File: rtl/ga25_vram_sched_if.sv
// CPU-side access bus of the GA25 VRAM slot scheduler.
// The CPU holds cpu_addr/cpu_din/cpu_we stable while cpu_req is high.
interface ga25_vram_sched_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        cpu_busy;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    input  cpu_dout, cpu_busy
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    output cpu_dout, cpu_busy
  );
endinterface

// File: rtl/ga25_vram_sched.sv
// GA25 VRAM slot scheduler: shares the single VRAM port between the two layer
// fetchers, the per-line rowscroll fetch and CPU accesses.
//
// mode       | meaning
// FETCH      | 8-slot loop: layer0 (0-1), layer1 (2-3), idle (4-5), CPU (6-7)
// ROWSCROLL  | 16-ce rowscroll fetch for both layers, slot counter frozen
//
// cpu_state  | meaning
// CPU_IDLE   | waiting for a cpu_req rising edge
// CPU_PENDING| request latched, waiting for FETCH slot 6
// CPU_ACTIVE | access on the VRAM bus, completes at slot 7
module ga25_vram_sched #(
  parameter logic [14:0] RS_BASE0 = 15'h7a00,
  parameter logic [14:0] RS_BASE1 = 15'h7c00
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce,
  input  logic                     line_start,
  input  logic [9:0]               y0,
  input  logic [9:0]               y1,
  input  logic [14:0]              layer_addr0,
  input  logic [14:0]              layer_addr1,
  output logic                     layer_load0,
  output logic                     layer_load1,
  output logic [15:0]              index_latch,
  output logic [9:0]               rowscroll0,
  output logic [9:0]               rowscroll1,
  ga25_vram_sched_if.slave         cpu,
  output logic [14:0]              vram_addr,
  output logic                     vram_we,
  output logic [15:0]              vram_data,
  input  logic [15:0]              vram_q
);

  typedef enum logic {FETCH, ROWSCROLL} mode_t;
  typedef enum logic [1:0] {CPU_IDLE, CPU_PENDING, CPU_ACTIVE} cpu_state_t;

  mode_t      mode, mode_nxt;
  cpu_state_t cpu_state, cpu_state_nxt;
  logic [2:0] slot, slot_nxt;
  logic [3:0] rs, rs_nxt;
  logic       rs_pending, rs_pending_nxt;
  logic       prev_req, prev_req_nxt;
  logic       we_lat, we_lat_nxt;
  logic [15:0] cpu_dout_r, cpu_dout_nxt;
  logic        layer_load0_nxt, layer_load1_nxt;
  logic [15:0] index_latch_nxt;
  logic [9:0]  rowscroll0_nxt, rowscroll1_nxt;
  logic [14:0] vram_addr_nxt;
  logic        vram_we_nxt;
  logic [15:0] vram_data_nxt;

  // Rowscroll tables have 512 entries; y bit 9 does not select a row.
  logic unused_ybits;
  assign unused_ybits = y0[9] ^ y1[9];

  assign cpu.cpu_dout = cpu_dout_r;
  assign cpu.cpu_busy = (cpu_state != CPU_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      mode        <= FETCH;
      cpu_state   <= CPU_IDLE;
      slot        <= '0;
      rs          <= '0;
      rs_pending  <= 1'b0;
      prev_req    <= 1'b0;
      we_lat      <= 1'b0;
      cpu_dout_r  <= '0;
      layer_load0 <= 1'b0;
      layer_load1 <= 1'b0;
      index_latch <= '0;
      rowscroll0  <= '0;
      rowscroll1  <= '0;
      vram_addr   <= '0;
      vram_we     <= 1'b0;
      vram_data   <= '0;
    end else begin
      mode        <= mode_nxt;
      cpu_state   <= cpu_state_nxt;
      slot        <= slot_nxt;
      rs          <= rs_nxt;
      rs_pending  <= rs_pending_nxt;
      prev_req    <= prev_req_nxt;
      we_lat      <= we_lat_nxt;
      cpu_dout_r  <= cpu_dout_nxt;
      layer_load0 <= layer_load0_nxt;
      layer_load1 <= layer_load1_nxt;
      index_latch <= index_latch_nxt;
      rowscroll0  <= rowscroll0_nxt;
      rowscroll1  <= rowscroll1_nxt;
      vram_addr   <= vram_addr_nxt;
      vram_we     <= vram_we_nxt;
      vram_data   <= vram_data_nxt;
    end
  end

  always_comb begin
    mode_nxt        = mode;
    cpu_state_nxt   = cpu_state;
    slot_nxt        = slot;
    rs_nxt          = rs;
    rs_pending_nxt  = rs_pending;
    prev_req_nxt    = cpu.cpu_req;
    we_lat_nxt      = we_lat;
    cpu_dout_nxt    = cpu_dout_r;
    layer_load0_nxt = layer_load0;
    layer_load1_nxt = layer_load1;
    index_latch_nxt = index_latch;
    rowscroll0_nxt  = rowscroll0;
    rowscroll1_nxt  = rowscroll1;
    vram_addr_nxt   = vram_addr;
    vram_we_nxt     = 1'b0;
    vram_data_nxt   = vram_data;

    if (ce) begin
      layer_load0_nxt = 1'b0;
      layer_load1_nxt = 1'b0;
      if (mode == FETCH) begin
        slot_nxt = slot + 3'd1;
        case (slot)
          3'd0: vram_addr_nxt = layer_addr0;
          3'd1: begin
            vram_addr_nxt[0] = 1'b1;
            index_latch_nxt  = vram_q;
            layer_load0_nxt  = 1'b1;
          end
          3'd2: vram_addr_nxt = layer_addr1;
          3'd3: begin
            vram_addr_nxt[0] = 1'b1;
            index_latch_nxt  = vram_q;
            layer_load1_nxt  = 1'b1;
          end
          3'd7: if (rs_pending) begin
            rs_pending_nxt = 1'b0;
            mode_nxt       = ROWSCROLL;
            rs_nxt         = 4'd0;
            slot_nxt       = slot;
          end
          default: ;
        endcase
        // Line start jumps to slot 7 so a completing CPU access is not lost.
        if (line_start) begin
          slot_nxt       = 3'd7;
          rs_pending_nxt = 1'b1;
        end
      end else begin
        rs_nxt = rs + 4'd1;
        case (rs)
          4'd4:  vram_addr_nxt  = RS_BASE0 + {6'b0, y0[8:0]};
          4'd7:  rowscroll0_nxt = vram_q[9:0];
          4'd8:  vram_addr_nxt  = RS_BASE1 + {6'b0, y1[8:0]};
          4'd10: rowscroll1_nxt = vram_q[9:0];
          4'd15: begin
            mode_nxt = FETCH;
            slot_nxt = 3'd0;
          end
          default: ;
        endcase
        if (line_start) rs_pending_nxt = 1'b1;
      end
    end

    case (cpu_state)
      CPU_IDLE: if (cpu.cpu_req && !prev_req) begin
        cpu_state_nxt = CPU_PENDING;
        we_lat_nxt    = cpu.cpu_we;
      end
      CPU_PENDING: if (ce && mode == FETCH && slot == 3'd6) begin
        vram_addr_nxt = cpu.cpu_addr;
        vram_data_nxt = cpu.cpu_din;
        vram_we_nxt   = we_lat;
        cpu_state_nxt = CPU_ACTIVE;
      end
      CPU_ACTIVE: if (ce && mode == FETCH && slot == 3'd7) begin
        cpu_dout_nxt  = vram_q;
        cpu_state_nxt = CPU_IDLE;
      end
      default: cpu_state_nxt = CPU_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ga25_vram_sched.sv
// Directed bench for ga25_vram_sched with a behavioural 32Kx16 VRAM
// (one-clk read latency, read-before-write).
module tb_ga25_vram_sched;
  logic        clk, reset, ce, line_start;
  logic [9:0]  y0, y1;
  logic [14:0] layer_addr0, layer_addr1;
  logic        layer_load0, layer_load1;
  logic [15:0] index_latch;
  logic [9:0]  rowscroll0, rowscroll1;
  logic [14:0] vram_addr;
  logic        vram_we;
  logic [15:0] vram_data, vram_q;

  ga25_vram_sched_if cpu_bus ();

  ga25_vram_sched dut (
    .clk(clk), .reset(reset), .ce(ce), .line_start(line_start),
    .y0(y0), .y1(y1), .layer_addr0(layer_addr0), .layer_addr1(layer_addr1),
    .layer_load0(layer_load0), .layer_load1(layer_load1),
    .index_latch(index_latch), .rowscroll0(rowscroll0), .rowscroll1(rowscroll1),
    .cpu(cpu_bus), .vram_addr(vram_addr), .vram_we(vram_we),
    .vram_data(vram_data), .vram_q(vram_q)
  );

  logic [15:0] mem [0:32767];
  bit          mem_ready = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;

  function automatic logic [15:0] fill(input logic [14:0] a);
    return {1'b0, a} ^ 16'ha5c3;
  endfunction

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 32768; i++) mem[i] <= fill(15'(i));
      mem[15'h7a05] <= 16'h0123;
      mem[15'h7c1f] <= 16'hfbff;
      mem_ready <= 1'b1;
    end else if (vram_we) begin
      mem[vram_addr] <= vram_data;
    end
    vram_q <= mem[vram_addr];
  end

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  initial begin ce = 1'b0; forever begin @(negedge clk); ce = ~ce; end end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_ce();
    @(posedge clk);
    while (ce !== 1'b1) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string t);
    chk({t, " vram_addr"}, 32'(vram_addr), 0);
    chk({t, " vram_we"}, 32'(vram_we), 0);
    chk({t, " vram_data"}, 32'(vram_data), 0);
    chk({t, " cpu_dout"}, 32'(cpu_bus.cpu_dout), 0);
    chk({t, " cpu_busy"}, 32'(cpu_bus.cpu_busy), 0);
    chk({t, " index_latch"}, 32'(index_latch), 0);
    chk({t, " rowscroll0"}, 32'(rowscroll0), 0);
    chk({t, " rowscroll1"}, 32'(rowscroll1), 0);
    chk({t, " load0"}, 32'(layer_load0), 0);
    chk({t, " load1"}, 32'(layer_load1), 0);
  endtask

  // One full CPU access: pulses counts vram_we clks, gap is clks from pulse to busy low.
  task automatic cpu_access(input string t, input logic we, input logic [14:0] a,
                            input logic [15:0] d, output int pulses,
                            output logic [14:0] paddr, output logic [15:0] pdata,
                            output int gap);
    bit done = 0;
    int ip = 0;
    pulses = 0; paddr = '0; pdata = '0; gap = -1;
    @(negedge clk);
    cpu_bus.cpu_we = we; cpu_bus.cpu_addr = a; cpu_bus.cpu_din = d; cpu_bus.cpu_req = 1'b1;
    @(posedge clk); #1;
    chk({t, " busy rise"}, 32'(cpu_bus.cpu_busy), 1);
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); #1;
      if (vram_we) begin pulses++; paddr = vram_addr; pdata = vram_data; ip = i; end
      if (!cpu_bus.cpu_busy) begin done = 1; gap = i - ip; end
    end
    chk({t, " busy fall"}, 32'(done), 1);
    @(negedge clk);
    cpu_bus.cpu_req = 1'b0;
  endtask

  task automatic align_slot4(input string t);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      wait_ce();
      if (layer_load1) seen = 1;
    end
    chk({t, " align"}, 32'(seen), 1);
  endtask

  initial begin
    int pulses, gap, loads, rises;
    bit saw_rs, prev_busy;
    logic [14:0] paddr;
    logic [15:0] pdata;

    reset = 1'b1; line_start = 1'b0;
    y0 = 10'h205; y1 = 10'h01f;
    layer_addr0 = 15'h0100; layer_addr1 = 15'h4200;
    cpu_bus.cpu_req = 1'b0; cpu_bus.cpu_we = 1'b0;
    cpu_bus.cpu_addr = '0; cpu_bus.cpu_din = '0;
    repeat (6) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk); reset = 1'b0;

    // Layer fetch slots 0-3
    wait_ce(); chk("s0 addr", 32'(vram_addr), 32'h0100); chk("s0 load0", 32'(layer_load0), 0);
    wait_ce(); chk("s1 addr", 32'(vram_addr), 32'h0101); chk("s1 load0", 32'(layer_load0), 1);
    chk("s1 index", 32'(index_latch), 32'(fill(15'h0100)));
    wait_ce(); chk("s2 addr", 32'(vram_addr), 32'h4200); chk("s2 load0", 32'(layer_load0), 0);
    wait_ce(); chk("s3 addr", 32'(vram_addr), 32'h4201); chk("s3 load1", 32'(layer_load1), 1);
    chk("s3 index", 32'(index_latch), 32'(fill(15'h4200)));

    // Rowscroll: line_start at slot 4
    line_start = 1'b1; wait_ce(); line_start = 1'b0;
    loads = 0;
    for (int k = 1; k <= 19; k++) begin
      wait_ce();
      if (k <= 18 && (layer_load0 || layer_load1)) loads++;
      if (k == 6)  chk("rs addr0", 32'(vram_addr), 32'h7a05);
      if (k == 9)  chk("rowscroll0", 32'(rowscroll0), 32'h123);
      if (k == 10) chk("rs addr1", 32'(vram_addr), 32'h7c1f);
      if (k == 12) chk("rowscroll1", 32'(rowscroll1), 32'h3ff);
      if (k == 18) chk("resume slot0", 32'(vram_addr), 32'h0100);
      if (k == 19) chk("resume load0", 32'(layer_load0), 1);
    end
    chk("rs no loads", 32'(loads), 0);

    // CPU write then read back
    cpu_access("wr40", 1'b1, 15'h0040, 16'hbeef, pulses, paddr, pdata, gap);
    chk("wr40 pulses", 32'(pulses), 1);
    chk("wr40 addr", 32'(paddr), 32'h0040);
    chk("wr40 data", 32'(pdata), 32'hbeef);
    chk("wr40 gap", 32'(gap), 2);
    chk("wr40 mem", 32'(mem[15'h0040]), 32'hbeef);
    cpu_access("rd40", 1'b0, 15'h0040, 16'h0000, pulses, paddr, pdata, gap);
    chk("rd40 pulses", 32'(pulses), 0);
    chk("rd40 dout", 32'(cpu_bus.cpu_dout), 32'hbeef);

    // Held request: one access only
    @(negedge clk);
    cpu_bus.cpu_we = 1'b1; cpu_bus.cpu_addr = 15'h0041; cpu_bus.cpu_din = 16'h1234;
    cpu_bus.cpu_req = 1'b1;
    pulses = 0; rises = 0; prev_busy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (vram_we) pulses++;
      if (cpu_bus.cpu_busy && !prev_busy) rises++;
      prev_busy = cpu_bus.cpu_busy;
    end
    chk("held pulses", 32'(pulses), 1);
    chk("held accesses", 32'(rises), 1);
    chk("held mem", 32'(mem[15'h0041]), 32'h1234);
    @(negedge clk); cpu_bus.cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    cpu_access("re-req", 1'b1, 15'h0041, 16'h2345, pulses, paddr, pdata, gap);
    chk("re-req pulses", 32'(pulses), 1);
    chk("re-req mem", 32'(mem[15'h0041]), 32'h2345);

    // Request pending when line_start hits slot 5: access after rowscroll
    align_slot4("ls5");
    cpu_bus.cpu_we = 1'b1; cpu_bus.cpu_addr = 15'h0042; cpu_bus.cpu_din = 16'h5555;
    cpu_bus.cpu_req = 1'b1;
    wait_ce();
    chk("ls5 busy", 32'(cpu_bus.cpu_busy), 1);
    line_start = 1'b1; wait_ce(); line_start = 1'b0;
    pulses = 0; saw_rs = 1'b0; paddr = '0;
    for (int i = 0; i < 100 && cpu_bus.cpu_busy; i++) begin
      @(posedge clk); #1;
      if (vram_addr == 15'h7a05 && pulses == 0) saw_rs = 1'b1;
      if (vram_we) begin pulses++; paddr = vram_addr; end
    end
    chk("ls5 done", 32'(cpu_bus.cpu_busy), 0);
    chk("ls5 rs first", 32'(saw_rs), 1);
    chk("ls5 pulses", 32'(pulses), 1);
    chk("ls5 addr", 32'(paddr), 32'h0042);
    chk("ls5 mem", 32'(mem[15'h0042]), 32'h5555);
    chk("ls5 rs tbl0", 32'(mem[15'h7a05]), 32'h0123);
    chk("ls5 rs tbl1", 32'(mem[15'h7c1f]), 32'hfbff);
    cpu_bus.cpu_req = 1'b0;

    // line_start at slot 6 with request pending: access first, then rowscroll
    align_slot4("ls6");
    cpu_bus.cpu_we = 1'b1; cpu_bus.cpu_addr = 15'h0043; cpu_bus.cpu_din = 16'h6666;
    cpu_bus.cpu_req = 1'b1;
    wait_ce(); wait_ce();
    line_start = 1'b1; wait_ce(); line_start = 1'b0;
    chk("ls6 we", 32'(vram_we), 1);
    chk("ls6 addr", 32'(vram_addr), 32'h0043);
    wait_ce();
    chk("ls6 busy", 32'(cpu_bus.cpu_busy), 0);
    repeat (5) wait_ce();
    chk("ls6 rs addr", 32'(vram_addr), 32'h7a05);
    chk("ls6 mem", 32'(mem[15'h0043]), 32'h6666);
    cpu_bus.cpu_req = 1'b0;

    // Reset while ACTIVE
    repeat (20) wait_ce();
    @(negedge clk);
    cpu_bus.cpu_we = 1'b1; cpu_bus.cpu_addr = 15'h0050; cpu_bus.cpu_din = 16'h7777;
    cpu_bus.cpu_req = 1'b1;
    pulses = 0;
    for (int i = 0; i < 100 && pulses == 0; i++) begin
      @(posedge clk); #1;
      if (vram_we) pulses++;
    end
    chk("rst active reached", 32'(pulses), 1);
    @(negedge clk); reset = 1'b1; cpu_bus.cpu_req = 1'b0;
    @(posedge clk); #1;
    chk_zero("rst active");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (vram_we || cpu_bus.cpu_busy) pulses++;
    end
    chk("post-rst idle", 32'(pulses), 0);

    // Reset while PENDING: the write is abandoned
    @(negedge clk);
    cpu_bus.cpu_addr = 15'h0051; cpu_bus.cpu_din = 16'h8888; cpu_bus.cpu_req = 1'b1;
    @(posedge clk); #1;
    chk("pend busy", 32'(cpu_bus.cpu_busy), 1);
    @(negedge clk); reset = 1'b1; cpu_bus.cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (vram_we) pulses++;
    end
    chk("pend no we", 32'(pulses), 0);
    chk("pend mem", 32'(mem[15'h0051]), 32'(fill(15'h0051)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
